// File: rtl/sigmoid_arbiter.sv
// Round-robin front end that shares one sigmoid_func unit among NUM_REQ requesters.
// Requester IDs ride a tag pipeline beside the unit; results queue in a credit-limited FIFO.

module sigmoid_arbiter_chk #(
  parameter int NUM_REQ    = 4,
  parameter int OBUF_DEPTH = 4,
  parameter int CNT_W      = 3
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               push,
  input  logic               pop,
  input  logic [CNT_W-1:0]   fifo_cnt,
  input  logic [NUM_REQ-1:0] req_ready
);
  a_no_overflow: assert property (@(posedge clk) disable iff (!reset_n)
    (push && !pop) |-> (fifo_cnt < CNT_W'(OBUF_DEPTH)));
  a_grant_onehot: assert property (@(posedge clk) disable iff (!reset_n)
    $onehot0(req_ready));
endmodule

module sigmoid_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_W     = 8,
  parameter int SIG_LAT    = 2,
  parameter int OBUF_DEPTH = 4,
  parameter int ID_W       = $clog2(NUM_REQ)
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic                      sig_en,
  output logic [DATA_W-1:0]         sig_in,
  input  logic [DATA_W-1:0]         sig_out,
  output logic                      rsp_valid,
  input  logic                      rsp_ready,
  output logic [DATA_W-1:0]         rsp_data,
  output logic [ID_W-1:0]           rsp_id,
  output logic                      busy
);
  localparam int CNT_W = $clog2(OBUF_DEPTH + 1);
  localparam int PTR_W = (OBUF_DEPTH > 1) ? $clog2(OBUF_DEPTH) : 1;
  localparam logic [ID_W-1:0]  LAST_ID    = ID_W'(NUM_REQ - 1);
  localparam logic [ID_W:0]    NUM_SUM    = (ID_W + 1)'(NUM_REQ);
  localparam logic [PTR_W-1:0] LAST_PTR   = PTR_W'(OBUF_DEPTH - 1);
  localparam logic [CNT_W:0]   CREDIT_MAX = (CNT_W + 1)'(OBUF_DEPTH);

  logic [ID_W-1:0]     rr_ptr_r;
  logic [SIG_LAT-1:0]  tag_vld_r;
  logic [ID_W-1:0]     tag_id_r [SIG_LAT];
  logic [DATA_W-1:0]   fifo_data_r [OBUF_DEPTH];
  logic [ID_W-1:0]     fifo_id_r [OBUF_DEPTH];
  logic [PTR_W-1:0]    rd_ptr_r, wr_ptr_r;
  logic [CNT_W-1:0]    fifo_cnt_r, inflight_r;

  logic [CNT_W:0]      credit_used_s;
  logic                issue_ok_s, grant_vld_s, handshake_s, push_s, pop_s;
  logic [2*NUM_REQ-1:0] req_dbl_s;
  logic [ID_W-1:0]     offset_s, grant_id_s;
  logic [ID_W:0]       grant_sum_s;

  function automatic logic [ID_W-1:0] lowest_set(input logic [NUM_REQ-1:0] vec);
    lowest_set = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (vec[k]) lowest_set = ID_W'(k);
      else        lowest_set = lowest_set;
    end
  endfunction

  assign credit_used_s = {1'b0, inflight_r} + {1'b0, fifo_cnt_r};
  assign issue_ok_s    = (credit_used_s < CREDIT_MAX);

  // Rotate requests so rr_ptr_r sits at bit 0, then take the lowest set bit.
  always_comb begin
    req_dbl_s   = {req_valid, req_valid} >> rr_ptr_r;
    offset_s    = lowest_set(req_dbl_s[NUM_REQ-1:0]);
    grant_sum_s = {1'b0, rr_ptr_r} + {1'b0, offset_s};
    grant_vld_s = reset_n & issue_ok_s & (|req_dbl_s[NUM_REQ-1:0]);
    if (grant_sum_s >= NUM_SUM) grant_id_s = ID_W'(grant_sum_s - NUM_SUM);
    else                        grant_id_s = grant_sum_s[ID_W-1:0];
  end

  assign req_ready   = grant_vld_s ? (NUM_REQ'(1) << grant_id_s) : '0;
  assign handshake_s = |(req_valid & req_ready);
  assign sig_en      = reset_n;
  assign sig_in      = grant_vld_s ? req_data[grant_id_s*DATA_W +: DATA_W] : '0;
  assign push_s      = tag_vld_r[SIG_LAT-1];
  assign rsp_valid   = (fifo_cnt_r != '0);
  assign pop_s       = rsp_valid & rsp_ready;
  assign rsp_data    = fifo_data_r[rd_ptr_r];
  assign rsp_id      = fifo_id_r[rd_ptr_r];
  assign busy        = (inflight_r != '0) | (fifo_cnt_r != '0);

  // Round-robin pointer moves past the winner only on an accepted request.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rr_ptr_r <= '0;
    end else if (handshake_s) begin
      rr_ptr_r <= (grant_id_s == LAST_ID) ? '0 : grant_id_s + ID_W'(1);
    end else begin
      rr_ptr_r <= rr_ptr_r;
    end
  end

  // Tags shift every cycle in lockstep with the fixed-latency unit.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tag_vld_r <= '0;
      for (int s = 0; s < SIG_LAT; s++) tag_id_r[s] <= '0;
    end else begin
      tag_vld_r[0] <= handshake_s;
      tag_id_r[0]  <= grant_id_s;
      for (int s = 1; s < SIG_LAT; s++) begin
        tag_vld_r[s] <= tag_vld_r[s-1];
        tag_id_r[s]  <= tag_id_r[s-1];
      end
    end
  end

  // Output FIFO: circular storage with independent read/write pointers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int e = 0; e < OBUF_DEPTH; e++) begin
        fifo_data_r[e] <= '0;
        fifo_id_r[e]   <= '0;
      end
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
    end else begin
      if (push_s) begin
        fifo_data_r[wr_ptr_r] <= sig_out;
        fifo_id_r[wr_ptr_r]   <= tag_id_r[SIG_LAT-1];
        wr_ptr_r <= (wr_ptr_r == LAST_PTR) ? '0 : wr_ptr_r + PTR_W'(1);
      end
      if (pop_s) begin
        rd_ptr_r <= (rd_ptr_r == LAST_PTR) ? '0 : rd_ptr_r + PTR_W'(1);
      end
    end
  end

  // Occupancy counters; together they form the credit count gating new issues.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      fifo_cnt_r <= '0;
      inflight_r <= '0;
    end else begin
      case ({push_s, pop_s})
        2'b10:   fifo_cnt_r <= fifo_cnt_r + CNT_W'(1);
        2'b01:   fifo_cnt_r <= fifo_cnt_r - CNT_W'(1);
        default: fifo_cnt_r <= fifo_cnt_r;
      endcase
      case ({handshake_s, push_s})
        2'b10:   inflight_r <= inflight_r + CNT_W'(1);
        2'b01:   inflight_r <= inflight_r - CNT_W'(1);
        default: inflight_r <= inflight_r;
      endcase
    end
  end

  sigmoid_arbiter_chk #(
    .NUM_REQ   (NUM_REQ),
    .OBUF_DEPTH(OBUF_DEPTH),
    .CNT_W     (CNT_W)
  ) u_chk (
    .clk      (clk),
    .reset_n  (reset_n),
    .push     (push_s),
    .pop      (pop_s),
    .fifo_cnt (fifo_cnt_r),
    .req_ready(req_ready)
  );
endmodule
